// File: rtl/rsp_pkg.sv
// Shared types and default constants for the response compactor.
package rsp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } rsp_state_e;

  localparam int              N_IN_DEF  = 5;
  localparam int              SIG_W_DEF = 16;
  localparam logic [15:0]     POLY_DEF  = 16'h1021;
  localparam logic [15:0]     SEED_DEF  = 16'hFFFF;

  typedef struct packed {
    logic [SIG_W_DEF-1:0] signature;
    logic [N_IN_DEF:0]    mismatch_cnt;
    logic                 first_fail_vld;
    logic [N_IN_DEF-1:0]  first_fail_idx;
    logic                 seq_err;
  } rsp_result_t;

endpackage

// File: rtl/serial_misr.sv
// Serial signature register: CRC-style shift with polynomial feedback,
// loadable with a seed; load takes priority over shift.
module serial_misr #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic             fb_s;

  assign fb_s = sig_q[SIG_W-1] ^ bit_in;

  // Next signature value
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (shift_en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (fb_s ? POLY : {SIG_W{1'b0}});
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      sig_q <= {SIG_W{1'b0}};
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/rsp_compactor.sv
// Response-capture stage: compacts one exhaustive sweep of DUT responses into
// a signature, mismatch count and first-fail index, then offers one result record.
module rsp_compactor
  import rsp_pkg::*;
#(
  parameter int               N_IN  = N_IN_DEF,
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [N_IN-1:0]  vec_in,
  input  logic             rsp_in,
  input  logic             exp_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SIG_W-1:0] signature,
  output logic [N_IN:0]    mismatch_cnt,
  output logic             first_fail_vld,
  output logic [N_IN-1:0]  first_fail_idx,
  output logic             seq_err,
  output logic             busy
);

  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_ONE  = {{N_IN{1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_MAX  = {1'b1, {N_IN{1'b0}}};

  rsp_state_e      state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffi_q, ffi_d;
  logic            seq_q, seq_d;
  logic            misr_load_s;
  logic            misr_shift_s;
  logic            accept_s;

  assign vec_ready = (state_q == COLLECT);
  assign res_valid = (state_q == REPORT);
  assign busy      = (state_q != IDLE);
  assign accept_s  = vec_valid && vec_ready;

  serial_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .CK       (CK),
    .reset    (reset),
    .load     (misr_load_s),
    .seed     (SEED),
    .shift_en (misr_shift_s),
    .bit_in   (rsp_in),
    .sig      (signature)
  );

  // Sweep sequencing, counters and first-fail capture
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    ffv_d        = ffv_q;
    ffi_d        = ffi_q;
    seq_d        = seq_q;
    misr_load_s  = 1'b0;
    misr_shift_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          misr_load_s = 1'b1;
          idx_d       = {N_IN{1'b0}};
          cnt_d       = {(N_IN+1){1'b0}};
          ffv_d       = 1'b0;
          ffi_d       = {N_IN{1'b0}};
          seq_d       = 1'b0;
          state_d     = COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (accept_s) begin
          misr_shift_s = 1'b1;
          if (rsp_in != exp_in) begin
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end else begin
              cnt_d = cnt_q;
            end
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = idx_q;
            end else begin
              ffv_d = ffv_q;
            end
          end else begin
            cnt_d = cnt_q;
          end
          // Index stays authoritative even when the applied vector disagrees
          if (vec_in != idx_q) begin
            seq_d = 1'b1;
          end else begin
            seq_d = seq_q;
          end
          idx_d = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            state_d = REPORT;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = REPORT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= {N_IN{1'b0}};
      cnt_q   <= {(N_IN+1){1'b0}};
      ffv_q   <= 1'b0;
      ffi_q   <= {N_IN{1'b0}};
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      seq_q   <= seq_d;
    end
  end

  assign mismatch_cnt   = cnt_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;
  assign seq_err        = seq_q;

endmodule

// File: tb/tb_rsp_compactor.sv
// Directed bench for rsp_compactor: a default-seed instance checked against a
// bit-serial CRC model and a zero-seed instance sharing the same stimulus.
module tb_rsp_compactor;
  import rsp_pkg::*;

  logic        CK        = 1'b0;
  logic        reset     = 1'b1;
  logic        start     = 1'b0;
  logic        vec_valid = 1'b0;
  logic [4:0]  vec_in    = 5'd0;
  logic        rsp_in    = 1'b0;
  logic        exp_in    = 1'b0;
  logic        res_ready = 1'b0;

  logic        vec_ready, res_valid, first_fail_vld, seq_err, busy;
  logic [15:0] signature;
  logic [5:0]  mismatch_cnt;
  logic [4:0]  first_fail_idx;

  logic        z_vec_ready, z_res_valid, z_ffv, z_seq, z_busy;
  logic [15:0] z_sig;
  logic [5:0]  z_cnt;
  logic [4:0]  z_ffi;

  int          n_tests = 0;
  int          n_fail  = 0;
  rsp_result_t m;
  logic [15:0] m_sig0;
  int          m_idx;
  logic [15:0] clean_sig;

  rsp_compactor dut (
    .CK(CK), .reset(reset), .start(start), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_in(vec_in), .rsp_in(rsp_in), .exp_in(exp_in),
    .res_valid(res_valid), .res_ready(res_ready), .signature(signature),
    .mismatch_cnt(mismatch_cnt), .first_fail_vld(first_fail_vld),
    .first_fail_idx(first_fail_idx), .seq_err(seq_err), .busy(busy)
  );

  rsp_compactor #(.SEED(16'h0000)) dut_z (
    .CK(CK), .reset(reset), .start(start), .vec_valid(vec_valid),
    .vec_ready(z_vec_ready), .vec_in(vec_in), .rsp_in(rsp_in), .exp_in(exp_in),
    .res_valid(z_res_valid), .res_ready(res_ready), .signature(z_sig),
    .mismatch_cnt(z_cnt), .first_fail_vld(z_ffv),
    .first_fail_idx(z_ffi), .seq_err(z_seq), .busy(z_busy)
  );

  always #5 CK = ~CK;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] s, input logic b);
    crc_step = {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic check_rec(input string tag);
    check({tag, "_sig"},  signature,      m.signature);
    check({tag, "_cnt"},  mismatch_cnt,   m.mismatch_cnt);
    check({tag, "_ffv"},  first_fail_vld, m.first_fail_vld);
    check({tag, "_ffi"},  first_fail_idx, m.first_fail_idx);
    check({tag, "_seq"},  seq_err,        m.seq_err);
    check({tag, "_zsig"}, z_sig,          m_sig0);
    check({tag, "_zrec"}, {z_cnt, z_ffv, z_ffi, z_seq},
          {m.mismatch_cnt, m.first_fail_vld, m.first_fail_idx, m.seq_err});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rec"}, {signature, mismatch_cnt, first_fail_vld, first_fail_idx, seq_err}, 32'd0);
    check({tag, "_ctl"}, {busy, vec_ready, res_valid}, 32'd0);
    check({tag, "_zrec"}, {z_sig, z_cnt, z_ffv, z_ffi, z_seq}, 32'd0);
  endtask

  task automatic start_sweep();
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    m = '0;
    m.signature = 16'hFFFF;
    m_sig0 = 16'h0000;
    m_idx = 0;
    check("start_ctl", {busy, vec_ready, res_valid}, 32'b110);
    check_rec("start");
  endtask

  task automatic send(input logic [4:0] v, input logic r, input logic e);
    int t = 0;
    while (!vec_ready && t < 20) begin
      @(posedge CK); #1;
      t++;
    end
    if (!vec_ready) check("vec_ready_timeout", 32'd0, 32'd1);
    vec_in = v; rsp_in = r; exp_in = e; vec_valid = 1'b1;
    @(posedge CK); #1;
    vec_valid = 1'b0;
    m.signature = crc_step(m.signature, r);
    m_sig0 = crc_step(m_sig0, r);
    if (r !== e) begin
      if (m.mismatch_cnt != 6'd32) m.mismatch_cnt = m.mismatch_cnt + 6'd1;
      if (!m.first_fail_vld) begin
        m.first_fail_vld = 1'b1;
        m.first_fail_idx = 5'(m_idx);
      end
    end
    if (v != 5'(m_idx)) m.seq_err = 1'b1;
    m_idx = (m_idx + 1) % 32;
    check("smp_sig", signature, m.signature);
    check("smp_cnt", mismatch_cnt, m.mismatch_cnt);
    check("smp_zsig", z_sig, m_sig0);
  endtask

  task automatic sweep(input logic [31:0] rsp_b, input logic [31:0] exp_b,
                       input bit bad_order, input bit gaps);
    logic [4:0] v;
    start_sweep();
    for (int i = 0; i < 32; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        @(posedge CK); #1;
        check_rec("stall");
        check("stall_rv", res_valid, 32'd0);
      end
      v = (bad_order && i == 2) ? 5'd3 : 5'(i);
      send(v, rsp_b[i], exp_b[i]);
      check("res_valid_lat", res_valid, (i == 31) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic finish_report(input int bp, input bit poke_start);
    for (int k = 0; k < bp; k++) begin
      res_ready = 1'b0;
      start = poke_start;
      @(posedge CK); #1;
      check("bp_ctl", {busy, vec_ready, res_valid}, 32'b101);
      check("bp_zctl", {z_busy, z_vec_ready, z_res_valid}, 32'b101);
      check_rec("bp");
    end
    start = poke_start;
    res_ready = 1'b1;
    @(posedge CK); #1;
    res_ready = 1'b0;
    start = 1'b0;
    check("idle_ctl", {busy, vec_ready, res_valid}, 32'b000);
    check("idle_zctl", {z_busy, z_vec_ready, z_res_valid}, 32'b000);
    check_rec("idle_hold");
  endtask

  initial begin
    repeat (2) @(posedge CK);
    #1;
    check_zero("in_reset");
    reset = 1'b0;
    @(posedge CK); #1;
    check_zero("after_reset");

    // Clean sweep
    sweep(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    check("clean_cnt", mismatch_cnt, 32'd0);
    check("clean_ffv", first_fail_vld, 32'd0);
    check("clean_seq", seq_err, 32'd0);
    check("clean_zsig", z_sig, 32'h0000);
    clean_sig = m.signature;
    finish_report(0, 1'b0);

    // Single fault at vector 13, with backpressure and start poked in REPORT
    sweep(32'h0000_2000, 32'h0000_0000, 1'b0, 1'b0);
    check("fault_cnt", mismatch_cnt, 32'd1);
    check("fault_ffv", first_fail_vld, 32'd1);
    check("fault_ffi", first_fail_idx, 32'd13);
    check("fault_seq", seq_err, 32'd0);
    finish_report(5, 1'b1);

    // Every vector fails
    sweep(~32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 1'b0);
    check("all_cnt", mismatch_cnt, 32'd32);
    check("all_ffi", first_fail_idx, 32'd0);
    check("all_ffv", first_fail_vld, 32'd1);
    finish_report(0, 1'b0);

    // Out-of-order vector and random stalls; fails at 4..7
    sweep(32'h0000_00F0, 32'h0000_0000, 1'b1, 1'b1);
    check("ord_seq", seq_err, 32'd1);
    check("ord_cnt", mismatch_cnt, 32'd4);
    check("ord_ffi", first_fail_idx, 32'd4);
    finish_report(2, 1'b0);

    // Reset mid-sweep, then a fresh clean sweep
    start_sweep();
    for (int i = 0; i < 10; i++) send(5'(i), 1'b1, 1'b0);
    reset = 1'b1;
    #2;
    check_zero("mid_reset");
    @(posedge CK); #1;
    reset = 1'b0;
    @(posedge CK); #1;
    check_zero("post_reset");
    sweep(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    check("rerun_sig", signature, clean_sig);
    check("rerun_zsig", z_sig, 32'h0000);
    check("rerun_cnt", mismatch_cnt, 32'd0);
    finish_report(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rsp_compactor.md
Name: rsp_compactor

Overview:
- Downstream response-capture stage for the exhaustive-vector trojan-detection flow.
- Consumes each applied input vector together with the DUT output bit and the golden expected bit.
- Compacts the response stream into a serial MISR/CRC signature, counts mismatches, records the first failing vector, and flags out-of-order vectors.
- Presents one result record per sweep on a valid/ready interface for the logging side.

Parameters:
- N_IN, 5, input-vector width; one sweep is 2^N_IN vectors.
- SIG_W, 16, signature width.
- POLY, 16'h1021, feedback polynomial (CRC-16-CCITT form).
- SEED, 16'hFFFF, signature value loaded on start.

Ports:
- CK  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep.
- vec_valid  in  1  vector/response sample valid.
- vec_ready  out  1  sample accepted when vec_valid && vec_ready.
- vec_in  in  N_IN  vector applied to the DUT for this sample.
- rsp_in  in  1  DUT output bit for vec_in.
- exp_in  in  1  golden expected bit for vec_in.
- res_valid  out  1  result record valid.
- res_ready  in  1  result record consumed.
- signature  out  SIG_W  compacted response signature.
- mismatch_cnt  out  N_IN+1  count of rsp_in != exp_in.
- first_fail_vld  out  1  at least one mismatch occurred.
- first_fail_idx  out  N_IN  vector index of the first mismatch.
- seq_err  out  1  sticky flag: vec_in differed from the expected index.
- busy  out  1  high in COLLECT or REPORT.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0, including signature; internal index counter idx=0.
- IDLE:
  - vec_ready=0, res_valid=0; result outputs hold the previous sweep's values.
  - On start: signature<=SEED, mismatch_cnt<=0, first_fail_vld<=0, first_fail_idx<=0, seq_err<=0, idx<=0, then go to COLLECT.
- COLLECT:
  - vec_ready=1 combinationally.
  - Each accepted sample updates all of the following in the same cycle:
    - signature <= {signature[SIG_W-2:0],1'b0} ^ ((signature[SIG_W-1]^rsp_in) ? POLY : 0).
    - If rsp_in!=exp_in: mismatch_cnt increments, saturating at 2^N_IN. If first_fail_vld==0, set first_fail_vld<=1 and first_fail_idx<=idx.
    - If vec_in!=idx: seq_err<=1 (sticky). Signature and counting still use the sample; idx stays authoritative.
    - idx <= idx+1.
  - Accepting the sample with idx==2^N_IN-1 moves to REPORT next cycle; idx wraps to 0.
  - Cycles with no accepted sample leave all state unchanged.
- REPORT:
  - res_valid=1, vec_ready=0.
  - All result outputs must be stable while res_valid && !res_ready.
  - res_valid && res_ready → IDLE next cycle.
- start is ignored in COLLECT and REPORT. start coincident with the res_ready handshake is also ignored.
- Latency: each sample is reflected in the outputs 1 cycle after acceptance; res_valid asserts 1 cycle after the last sample is accepted.
- Reset mid-sweep (any state): immediate return to IDLE with all outputs 0; the partial sweep is discarded.
- busy=1 in COLLECT and REPORT, 0 in IDLE.

Decomposition:
- Shared package rsp_pkg holds:
  - state enum {IDLE, COLLECT, REPORT};
  - default constants N_IN_DEF, SIG_W_DEF, POLY_DEF, SEED_DEF;
  - a result struct type {signature, mismatch_cnt, first_fail_vld, first_fail_idx, seq_err}.
- One natural sub-module, serial_misr, holds the signature register and feedback with ports load/seed/shift_en/bit_in/sig.
- The FSM, counters and first-fail capture live in rsp_compactor.

Test Plan:
- Clean sweep: start; vectors 0..31 in order with rsp=exp=0, SEED overridden to 0 → signature=16'h0000, mismatch_cnt=0, first_fail_vld=0, seq_err=0, res_valid 1 cycle after vector 31.
- Single fault: default SEED; exp=0 for all; rsp=1 only at vector 13 → mismatch_cnt=1, first_fail_vld=1, first_fail_idx=13; signature matches the bench's bit-serial CRC reference model.
- Saturation/all-fail: rsp=~exp for all 32 vectors → mismatch_cnt=32, first_fail_idx=0; no wrap.
- Ordering and stalls: vec_in sequence 0,1,3,3,4..31 with random vec_valid gaps → seq_err=1; res_valid only after 32 accepted samples; stall cycles leave all outputs unchanged.
- Backpressure: hold res_ready=0 for 5 cycles in REPORT; pulse start during REPORT → outputs stable, start ignored, IDLE the cycle after res_ready=1.
- Reset mid-sweep: assert reset after 10 samples, release, then start a new clean sweep → after reset all outputs 0, busy=0, vec_ready=0; the new sweep produces the same results as the clean-sweep case.
